// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  localparam int unsigned MAX_DEC = 9999;
  localparam int unsigned BCD_W   = 16;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble corrector: adds 3 to any BCD nibble of 5 or more.
module bcd_add3 (
  input  logic [3:0] in_i,
  output logic [3:0] out_o
);

  assign out_o = (in_i >= 4'd5) ? in_i + 4'd3 : in_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per clock) feeding the
// four-digit display bus; outputs only move in the final cycle of a conversion.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int unsigned BIN_W = 14
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd_out,
  output logic             ovf
);

  localparam int unsigned CntW = $clog2(BIN_W + 1);

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   sh_q, sh_d;
  logic [BCD_W-1:0]   acc_q, acc_d;
  logic [BCD_W-1:0]   acc_adj;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               sat;
  logic               unused_acc_msb;

  for (genvar i = 0; i < BCD_W / 4; i++) begin : g_add3
    bcd_add3 u_add3 (
      .in_i  (acc_q[4*i +: 4]),
      .out_o (acc_adj[4*i +: 4])
    );
  end

  // The top acc bit is shifted out and lost; values up to 9999 never reach it.
  assign unused_acc_msb = acc_adj[BCD_W-1];

  assign sat = 32'(bin_in) > MAX_DEC;

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    // Delayed one cycle so busy also covers the cycle in which done is high.
    busy_d     = (state_q != StIdle);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sh_d       = sat ? BIN_W'(MAX_DEC) : bin_in;
          acc_d      = '0;
          cnt_d      = CntW'(BIN_W);
          ovf_pend_d = sat;
          state_d    = StShift;
        end
      end
      StShift: begin
        acc_d = {acc_adj[BCD_W-2:0], sh_q[BIN_W-1]};
        sh_d  = {sh_q[BIN_W-2:0], 1'b0};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        bcd_d   = acc_q;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q    <= StIdle;
      sh_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: vector table, hand-written corner sequences
// and random values against a decimal-arithmetic reference model.
module tb_bin2bcd_seq;

  localparam int unsigned BinW = 14;

  logic            clk    = 1'b0;
  logic            clr_n  = 1'b1;
  logic            start  = 1'b0;
  logic [BinW-1:0] bin_in = '0;
  logic            busy;
  logic            done;
  logic            ovf;
  logic [15:0]     bcd_out;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    int unsigned val;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  bin2bcd_seq #(.BIN_W(BinW)) dut (
    .clk     (clk),
    .clr_n   (clr_n),
    .start   (start),
    .bin_in  (bin_in),
    .busy    (busy),
    .done    (done),
    .bcd_out (bcd_out),
    .ovf     (ovf)
  );

  always #5 clk = ~clk;

  // {ovf, bcd}: saturate at 9999, then split into decimal digits.
  function automatic logic [16:0] ref_model(input int unsigned v);
    int unsigned x;
    logic [15:0] b;
    x       = (v > 9999) ? 9999 : v;
    b[3:0]   = 4'(x % 10);
    b[7:4]   = 4'((x / 10) % 10);
    b[11:8]  = 4'((x / 100) % 10);
    b[15:12] = 4'((x / 1000) % 10);
    return {(v > 9999), b};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic conv_check(input int unsigned v, input logic [15:0] exp_bcd, input logic exp_ovf);
    int lat;
    int bsy;
    bin_in = BinW'(v);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    lat = 0;
    bsy = 0;
    while (lat < 40) begin
      tick();
      lat++;
      if (busy) bsy++;
      if (done) break;
    end
    check($sformatf("done_seen(%0d)", v), done, 1);
    check($sformatf("bcd(%0d)", v), bcd_out, exp_bcd);
    check($sformatf("ovf(%0d)", v), ovf, exp_ovf);
    check($sformatf("latency(%0d)", v), lat, BinW + 1);
    check($sformatf("busy_cycles(%0d)", v), bsy, BinW + 1);
    tick();
    check($sformatf("done_one_cycle(%0d)", v), done, 0);
    check($sformatf("busy_falls(%0d)", v), busy, 0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [16:0] exp;
    int          ndone;

    vecs.push_back('{0,     16'h0000, 1'b0});
    vecs.push_back('{1234,  16'h1234, 1'b0});
    vecs.push_back('{9999,  16'h9999, 1'b0});
    vecs.push_back('{12000, 16'h9999, 1'b1});
    vecs.push_back('{10000, 16'h9999, 1'b1});
    vecs.push_back('{16383, 16'h9999, 1'b1});
    vecs.push_back('{9,     16'h0009, 1'b0});
    vecs.push_back('{10,    16'h0010, 1'b0});
    vecs.push_back('{8421,  16'h8421, 1'b0});
    vecs.push_back('{5678,  16'h5678, 1'b0});

    // Asynchronous reset values.
    #2 clr_n = 1'b0;
    #10;
    check("rst_bcd", bcd_out, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    tick();
    clr_n = 1'b1;
    tick();

    foreach (vecs[i]) conv_check(vecs[i].val, vecs[i].bcd, vecs[i].ovf);

    // Starts while busy are dropped; a start right after done is accepted.
    bin_in = BinW'(42);
    start  = 1'b1;
    tick();
    ndone = 0;
    for (int i = 1; i <= 40; i++) begin
      if (i == 3 || i == 15 || i == 16) begin
        start  = 1'b1;
        bin_in = BinW'(7);
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          check("drop_first_at", i, 15);
          check("drop_first_bcd", bcd_out, 16'h0042);
        end else begin
          check("next_start_at", i, 31);
          check("next_start_bcd", bcd_out, 16'h0007);
        end
      end
    end
    start = 1'b0;
    check("drop_done_count", ndone, 2);

    // Reset mid-conversion aborts and clears the outputs.
    conv_check(5678, 16'h5678, 1'b0);
    bin_in = BinW'(100);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (5) tick();
    clr_n = 1'b0;
    #1;
    check("abort_bcd", bcd_out, 16'h0000);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (3) tick();
    clr_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);
    conv_check(100, 16'h0100, 1'b0);

    // Saturation boundary.
    for (int unsigned v = 9995; v <= 10005; v++) begin
      exp = ref_model(v);
      conv_check(v, exp[15:0], exp[16]);
    end

    // Random values across the full input range.
    repeat (150) begin
      int unsigned v;
      v   = $urandom_range(16383, 0);
      exp = ref_model(v);
      conv_check(v, exp[15:0], exp[16]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential binary-to-BCD converter that sits directly upstream of the 4-digit seven-segment display driver. It takes an unsigned binary value and converts it to four packed BCD digits using the iterative shift-add-3 (double-dabble) algorithm, one bit per clock. Its registered 16-bit output drives the display driver's 16-bit digit bus, so the board shows decimal values instead of hex.

## Interface
Parameters:
- BIN_W, 14: width of the binary input. Legal range is 4..14; 14 bits covers 0..9999.

Ports:
- clk  in  1  system clock; same clock as the display driver.
- clr_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request; samples bin_in.
- bin_in  in  BIN_W  unsigned value to convert.
- busy  out  1  high while a conversion is in progress.
- done  out  1  one-cycle pulse when bcd_out is updated.
- bcd_out  out  16  packed BCD: [15:12] thousands, [11:8] hundreds, [7:4] tens, [3:0] units; feeds the display input bus.
- ovf  out  1  set if the last accepted bin_in was greater than 9999; valid together with bcd_out.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - When start=1, latch the operand into shift register sh, clear scratch BCD register acc, load bit counter cnt=BIN_W, go to SHIFT.
  - If bin_in > 9999, latch 9999 instead and record ovf_pending=1. Otherwise ovf_pending=0.
- SHIFT, each cycle:
  - For each acc nibble, if the nibble is ≥5, add 3 (4-bit add, no carry out of the nibble).
  - Then shift {acc, sh} left by 1, so the MSB of sh enters acc[0].
  - Decrement cnt. When cnt reaches 1 (last shift), go to DONE.
- DONE, one cycle:
  - Copy acc to bcd_out and ovf_pending to ovf; pulse done=1.
  - Next state is IDLE.
  - A start in DONE is ignored; start is only accepted in IDLE.
- busy=1 in SHIFT and DONE, 0 in IDLE.
- start while busy=1 is dropped. It is not queued and no error is flagged.
- bcd_out and ovf change only in the DONE cycle, so the display bus never shows partial results.
- Width rules:
  - acc is 16 bits; sh is BIN_W bits.
  - The saturation compare is done on the full BIN_W-bit input.
  - For BIN_W < 14 saturation can never trigger, and ovf stays 0.

## Timing
- Start accepted at rising edge T0 (state IDLE, start=1).
- SHIFT occupies edges T1..T(BIN_W).
- DONE state holds in the cycle after edge T(BIN_W).
- bcd_out, ovf and done are all registered. They update at edge T(BIN_W+1), so latency from start to done is BIN_W+1 cycles (15 for the default).
- done is high for exactly one cycle.
- busy rises at T1 (the edge after start) and falls at T(BIN_W+2) (the edge after done).
- Minimum start-to-start spacing is BIN_W+2 cycles.
- Reset values, applied asynchronously on clr_n=0:
  - state=IDLE, busy=0, done=0, ovf=0, bcd_out=16'h0000, acc=0, sh=0, cnt=0.
- Reset mid-conversion aborts the conversion. bcd_out returns to 0 and no done pulse is produced.
- Reset release is synchronised externally; the block does not double-flop clr_n.

## Structure
- Shared package bin2bcd_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - localparam MAX_DEC = 9999;
  - localparam BCD_W = 16.
- Sub-module bcd_add3: combinational 4-bit nibble corrector (in ≥5 ? in+3 : in). Instantiate it four times in a generate loop over the acc nibbles.
- The top level holds the FSM, counter, shift registers and output registers. Target size is about 150 lines.

## Test plan
- Reset, then start with bin_in=0 → done at cycle 15, bcd_out=16'h0000, ovf=0.
- start with bin_in=1234 → done exactly 15 cycles after start, bcd_out=16'h1234, busy high for 15 cycles.
- start with bin_in=9999 → bcd_out=16'h9999, ovf=0. Then start with bin_in=12000 → bcd_out=16'h9999, ovf=1.
- start with bin_in=42, then start with bin_in=7 on cycles 3 and 15 → only one done, bcd_out=16'h0042. A start in the cycle after done, with bin_in=7, gives bcd_out=16'h0007.
- Convert 5678 (bcd_out=16'h5678), then start 100 and pull clr_n low at cycle 5 → bcd_out=16'h0000, busy=0, no done pulse. After release, start 100 → bcd_out=16'h0100.
- Exhaustive sweep 0..16383 compared against a reference model → every result matches, with ovf set exactly for values > 9999.
